// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM plus a 16-word memory-mapped I/O page
module dmem_responder #(
    parameter int                ADDR_W  = 10,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = 10'h3F0,
    parameter int                GPIO_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] address_DMEM,
    input  logic [DATA_W-1:0] write_data_DMEM,
    input  logic              MemWrite,
    input  logic              MemRead,
    output logic [DATA_W-1:0] data_DMEM,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out
);

    localparam int RAM_WORDS = int'(IO_BASE);

    localparam logic [ADDR_W-1:0] OFF_GPIO_OUT = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] OFF_GPIO_IN  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OFF_CYCLE    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] OFF_SCRATCH  = ADDR_W'(3);

    logic [DATA_W-1:0] r_ram [0:RAM_WORDS-1];
    logic [GPIO_W-1:0] r_gpio_out;
    logic [GPIO_W-1:0] r_sync1;
    logic [GPIO_W-1:0] r_sync2;
    logic [31:0]       r_cycle;
    logic [DATA_W-1:0] r_scratch;
    logic [DATA_W-1:0] r_data;

    logic              w_is_ram;
    logic [ADDR_W-1:0] w_offset;
    logic              w_wr_ram;
    logic              w_wr_gpio;
    logic              w_wr_scratch;
    logic [DATA_W-1:0] w_rd_data;

    assign w_is_ram     = (address_DMEM < IO_BASE);
    assign w_offset     = address_DMEM - IO_BASE;
    assign w_wr_ram     = MemWrite & w_is_ram;
    assign w_wr_gpio    = MemWrite & ~w_is_ram & (w_offset == OFF_GPIO_OUT);
    assign w_wr_scratch = MemWrite & ~w_is_ram & (w_offset == OFF_SCRATCH);

    // Write-first: a store to a writable word in the same cycle wins over the old contents.
    always_comb begin
        w_rd_data = '0;
        if (w_wr_ram | w_wr_gpio | w_wr_scratch) begin
            w_rd_data = write_data_DMEM;
        end else if (w_is_ram) begin
            w_rd_data = r_ram[address_DMEM];
        end else begin
            case (w_offset)
                OFF_GPIO_OUT: w_rd_data = DATA_W'(r_gpio_out);
                OFF_GPIO_IN:  w_rd_data = DATA_W'(r_sync2);
                OFF_CYCLE:    w_rd_data = DATA_W'(r_cycle);
                OFF_SCRATCH:  w_rd_data = r_scratch;
                default:      w_rd_data = '0;
            endcase
        end
    end

    // RAM has no reset so it maps onto a plain memory macro; reset only blocks the store.
    always_ff @(posedge CLK) begin
        if (!RST && w_wr_ram) begin
            r_ram[address_DMEM] <= write_data_DMEM;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_cycle    <= '0;
            r_scratch  <= '0;
            r_data     <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            r_cycle <= r_cycle + 32'd1;
            if (w_wr_gpio) begin
                r_gpio_out <= write_data_DMEM[GPIO_W-1:0];
            end
            if (w_wr_scratch) begin
                r_scratch <= write_data_DMEM;
            end
            if (MemRead) begin
                r_data <= w_rd_data;
            end
        end
    end

    assign data_DMEM = r_data;
    assign gpio_out  = r_gpio_out;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and randomized checks of dmem_responder against a behavioural model
module tb_dmem_responder;

    logic        CLK;
    logic        RST;
    logic [9:0]  address_DMEM;
    logic [31:0] write_data_DMEM;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] data_DMEM;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;

    dmem_responder #(
        .ADDR_W (10),
        .DATA_W (32),
        .IO_BASE(10'h3F0),
        .GPIO_W (16)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .address_DMEM   (address_DMEM),
        .write_data_DMEM(write_data_DMEM),
        .MemWrite       (MemWrite),
        .MemRead        (MemRead),
        .data_DMEM      (data_DMEM),
        .gpio_in        (gpio_in),
        .gpio_out       (gpio_out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: memory array, plain I/O variables, edge counter and a two-deep delay queue.
    logic [31:0] m_mem [1024];
    bit          m_mem_known [1024];
    logic [31:0] m_data;
    bit          m_data_known = 0;
    bit          m_ready = 0;
    logic [15:0] m_gpio;
    logic [31:0] m_scratch;
    logic [31:0] m_cycle;
    logic [15:0] m_delay [$];

    always @(posedge CLK) begin
        int unsigned a;
        int unsigned off;
        bit writable;
        a = address_DMEM;
        if (RST) begin
            m_ready      = 1;
            m_data       = 32'h0;
            m_data_known = 1;
            m_gpio       = 16'h0;
            m_scratch    = 32'h0;
            m_cycle      = 32'h0;
            m_delay      = '{16'h0, 16'h0};
        end else if (m_ready) begin
            off      = (a >= 32'h3F0) ? a - 32'h3F0 : 0;
            writable = (a < 32'h3F0) || off == 0 || off == 3;
            if (MemRead) begin
                m_data_known = 1;
                if (MemWrite && writable) m_data = write_data_DMEM;
                else if (a < 32'h3F0) begin
                    m_data       = m_mem[a];
                    m_data_known = m_mem_known[a];
                end else if (off == 0) m_data = {16'h0, m_gpio};
                else if (off == 1) m_data = {16'h0, m_delay[0]};
                else if (off == 2) m_data = m_cycle;
                else if (off == 3) m_data = m_scratch;
                else m_data = 32'h0;
            end
            if (MemWrite) begin
                if (a < 32'h3F0) begin
                    m_mem[a]       = write_data_DMEM;
                    m_mem_known[a] = 1;
                end else if (off == 0) m_gpio = write_data_DMEM[15:0];
                else if (off == 3) m_scratch = write_data_DMEM;
            end
            m_cycle = m_cycle + 32'd1;
            void'(m_delay.pop_front());
            m_delay.push_back(gpio_in);
        end
    end

    always @(negedge CLK) begin
        if (m_ready) begin
            if (m_data_known) check("model data_DMEM", data_DMEM, m_data);
            check("model gpio_out", {16'h0, gpio_out}, {16'h0, m_gpio});
        end
    end

    task automatic cyc(input logic rst, input logic rd, input logic wr,
                       input logic [9:0] a, input logic [31:0] d);
        RST             = rst;
        MemRead         = rd;
        MemWrite        = wr;
        address_DMEM    = a;
        write_data_DMEM = d;
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        logic [31:0] c0;
        logic [9:0]  ra;
        RST = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        address_DMEM = '0; write_data_DMEM = '0; gpio_in = 16'h0;

        // Reset then idle; CYCLE read at third edge after release returns 2.
        cyc(1, 0, 0, 10'h0, 32'h0);
        cyc(1, 0, 0, 10'h0, 32'h0);
        check("reset data_DMEM", data_DMEM, 32'h0);
        check("reset gpio_out", {16'h0, gpio_out}, 32'h0);
        cyc(0, 0, 0, 10'h0, 32'h0);
        cyc(0, 0, 0, 10'h0, 32'h0);
        cyc(0, 1, 0, 10'h3F2, 32'h0);
        check("cycle after reset", data_DMEM, 32'd2);

        // RAM store/load including the last RAM word.
        cyc(0, 0, 1, 10'h000, 32'hDEADBEEF);
        cyc(0, 0, 1, 10'h3EF, 32'h12345678);
        cyc(0, 1, 0, 10'h000, 32'h0);
        check("ram read 0", data_DMEM, 32'hDEADBEEF);
        cyc(0, 1, 0, 10'h3EF, 32'h0);
        check("ram read 3EF", data_DMEM, 32'h12345678);
        cyc(0, 0, 0, 10'h000, 32'h0);
        check("hold with MemRead=0", data_DMEM, 32'h12345678);

        // Write-first collision.
        cyc(0, 0, 1, 10'h005, 32'h0);
        cyc(0, 1, 1, 10'h005, 32'hA5A5A5A5);
        check("write-first ram", data_DMEM, 32'hA5A5A5A5);
        cyc(0, 1, 0, 10'h005, 32'h0);
        check("ram read 5 after collision", data_DMEM, 32'hA5A5A5A5);

        // I/O page.
        cyc(0, 0, 1, 10'h3F0, 32'hFFFF1234);
        check("gpio_out after store", {16'h0, gpio_out}, 32'h00001234);
        cyc(0, 1, 0, 10'h3F0, 32'h0);
        check("gpio_out readback", data_DMEM, 32'h00001234);
        cyc(0, 1, 0, 10'h3F2, 32'h0);
        c0 = data_DMEM;
        cyc(0, 0, 1, 10'h3F2, 32'h0);
        cyc(0, 1, 0, 10'h3F2, 32'h0);
        check("cycle ignores store", data_DMEM - c0, 32'd2);
        cyc(0, 0, 1, 10'h3F7, 32'hCAFEF00D);
        cyc(0, 1, 0, 10'h3F7, 32'h0);
        check("reserved 3F7 reads 0", data_DMEM, 32'h0);
        cyc(0, 1, 0, 10'h3FF, 32'h0);
        check("reserved 3FF reads 0", data_DMEM, 32'h0);

        // GPIO_IN synchronizer latency.
        gpio_in = 16'h00C3;
        cyc(0, 1, 0, 10'h3F1, 32'h0);
        check("gpio_in edge 1", data_DMEM, 32'h0);
        cyc(0, 1, 0, 10'h3F1, 32'h0);
        check("gpio_in edge 2", data_DMEM, 32'h0);
        cyc(0, 1, 0, 10'h3F1, 32'h0);
        check("gpio_in edge 3", data_DMEM, 32'h000000C3);

        // Reset mid-run: store during reset is dropped, RAM survives.
        cyc(0, 0, 1, 10'h3F3, 32'h00000055);
        cyc(0, 0, 1, 10'h00A, 32'h00000077);
        cyc(1, 1, 1, 10'h00A, 32'h00000099);
        check("gpio_out after mid reset", {16'h0, gpio_out}, 32'h0);
        cyc(0, 1, 0, 10'h3F2, 32'h0);
        check("cycle restarts", data_DMEM, 32'h0);
        cyc(0, 1, 0, 10'h3F3, 32'h0);
        check("scratch cleared", data_DMEM, 32'h0);
        cyc(0, 1, 0, 10'h00A, 32'h0);
        check("ram kept over reset", data_DMEM, 32'h00000077);

        // Fill the random RAM pool so every model read is known.
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, 10'(i), $urandom);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 10'(10'h3E8 + i), $urandom);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 2))
                0:       ra = 10'($urandom_range(0, 15));
                1:       ra = 10'(10'h3E8 + $urandom_range(0, 7));
                default: ra = 10'(10'h3F0 + $urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 7) == 0) gpio_in = 16'($urandom);
            cyc(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), ra, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
